fft_stage_scheduler: RTL and testbench

FFT_STAGE_SCHEDULER -- requirements
Module: fft_stage_scheduler

---
 rtl/fft_pkg.sv | 17 +
 rtl/fft_addr_gen.sv | 30 +++
 rtl/fft_stage_scheduler.sv | 152 +++++++++++++++
 tb/tb_fft_stage_scheduler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the radix-2 FFT stage scheduler.
package fft_pkg;

  localparam int N_LOG2_DEF  = 4;
  localparam int RD_LAT_DEF  = 1;
  localparam int BFU_LAT_DEF = 5;
  // Cycles from a read strobe to the matching write-back strobe.
  localparam int PIPE_DEF    = RD_LAT_DEF + BFU_LAT_DEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address generator for an in-place radix-2 DIT FFT.
// For stage s and butterfly k: span = 2^s, pos = k mod span, grp = k >> s,
// a = grp*2*span + pos, b = a + span, twiddle = pos << (N_LOG2-1-s).
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF
) (
  input  logic [$clog2(N_LOG2)-1:0] stage,
  input  logic [N_LOG2-2:0]         k,
  output logic [N_LOG2-1:0]         addr_a,
  output logic [N_LOG2-1:0]         addr_b,
  output logic [N_LOG2-2:0]         tw_addr
);

  logic [N_LOG2-2:0] pos_mask;
  logic [N_LOG2-2:0] pos;
  logic [N_LOG2-2:0] grp;

  // Split k into group and position, then place the operand pair.
  always_comb begin
    pos_mask = ~({(N_LOG2-1){1'b1}} << stage);
    pos      = k & pos_mask;
    grp      = k >> stage;
    addr_a   = ({1'b0, grp} << (int'(stage) + 1)) | {1'b0, pos};
    addr_b   = addr_a + (N_LOG2'(1) << stage);
    tw_addr  = pos << (N_LOG2 - 1 - int'(stage));
  end

endmodule

// File: rtl/fft_stage_scheduler.sv
// Read/write-back scheduler for an in-place radix-2 DIT FFT.
// start is a one-cycle request sampled only in IDLE; there is no ready
// signal, a start seen in any other state is simply dropped.
// Per stage: N/2 back-to-back issue cycles, then PIPE drain cycles so the
// last write-back of a stage completes before the next stage reads.
module fft_stage_scheduler
  import fft_pkg::*;
#(
  parameter int N_LOG2  = N_LOG2_DEF,
  parameter int RD_LAT  = RD_LAT_DEF,
  parameter int BFU_LAT = BFU_LAT_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      rd_en,
  output logic [N_LOG2-1:0]         rd_addr_a,
  output logic [N_LOG2-1:0]         rd_addr_b,
  output logic [N_LOG2-2:0]         tw_addr,
  output logic                      wr_en,
  output logic [N_LOG2-1:0]         wr_addr_a,
  output logic [N_LOG2-1:0]         wr_addr_b,
  output logic [$clog2(N_LOG2)-1:0] stage
);

  localparam int PIPE = RD_LAT + BFU_LAT;
  localparam int SW   = $clog2(N_LOG2);
  localparam int KW   = N_LOG2 - 1;
  localparam int CW   = $clog2(PIPE + 1);

  localparam logic [KW-1:0] K_LAST     = '1;
  localparam logic [SW-1:0] STAGE_LAST = SW'(N_LOG2 - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(PIPE - 1);

  state_t          state, state_nxt;
  logic [SW-1:0]   stage_nxt;
  logic [KW-1:0]   k, k_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [N_LOG2-1:0] gen_a, gen_b;
  logic [KW-1:0]     gen_tw;

  logic [PIPE-1:0]   en_dly;
  logic [N_LOG2-1:0] a_dly [PIPE];
  logic [N_LOG2-1:0] b_dly [PIPE];

  // Next-state, stage and butterfly-index logic.
  always_comb begin
    state_nxt = state;
    stage_nxt = stage;
    k_nxt     = k;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ISSUE;
          stage_nxt = '0;
          k_nxt     = '0;
        end
      end
      ISSUE: begin
        if (k == K_LAST) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end else begin
          k_nxt = k + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt == CNT_LAST) begin
          if (stage == STAGE_LAST) begin
            state_nxt = FINISH;
          end else begin
            state_nxt = ISSUE;
            stage_nxt = stage + 1'b1;
            k_nxt     = '0;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Addresses are generated from the next stage/k so they register with rd_en.
  fft_addr_gen #(
    .N_LOG2(N_LOG2)
  ) u_addr_gen (
    .stage  (stage_nxt),
    .k      (k_nxt),
    .addr_a (gen_a),
    .addr_b (gen_b),
    .tw_addr(gen_tw)
  );

  // State register plus registered read-side and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      stage     <= '0;
      k         <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
    end else begin
      state <= state_nxt;
      stage <= stage_nxt;
      k     <= k_nxt;
      cnt   <= cnt_nxt;
      busy  <= (state_nxt == ISSUE) || (state_nxt == DRAIN);
      done  <= (state_nxt == FINISH);
      rd_en <= (state_nxt == ISSUE);
      if (state_nxt == ISSUE) begin
        rd_addr_a <= gen_a;
        rd_addr_b <= gen_b;
        tw_addr   <= gen_tw;
      end
    end
  end

  // Write-back delay line: read strobe and addresses delayed by PIPE cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_dly <= '0;
      for (int i = 0; i < PIPE; i++) begin
        a_dly[i] <= '0;
        b_dly[i] <= '0;
      end
    end else begin
      en_dly[0] <= rd_en;
      a_dly[0]  <= rd_addr_a;
      b_dly[0]  <= rd_addr_b;
      for (int i = 1; i < PIPE; i++) begin
        en_dly[i] <= en_dly[i-1];
        a_dly[i]  <= a_dly[i-1];
        b_dly[i]  <= b_dly[i-1];
      end
    end
  end

  assign wr_en     = en_dly[PIPE-1];
  assign wr_addr_a = a_dly[PIPE-1];
  assign wr_addr_b = b_dly[PIPE-1];

endmodule

// File: tb/tb_fft_stage_scheduler.sv
// Bench for fft_stage_scheduler (N=16, RD_LAT=1, BFU_LAT=5).
// The model counts cycles since an accepted start and derives every output
// from the schedule arithmetic: each stage is N/2 issue cycles + PIPE drain.
module tb_fft_stage_scheduler;

  localparam int N_LOG2 = 4;
  localparam int HALF   = 8;
  localparam int PIPE   = 6;
  localparam int STG    = 4;
  localparam int PER    = HALF + PIPE;
  localparam int LAST_C = STG * PER;
  localparam int DONE_C = LAST_C + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy, done, rd_en, wr_en;
  logic [3:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [2:0] tw_addr;
  logic [1:0] stage;

  int checks = 0;
  int errors = 0;
  int mcyc   = 0;

  int log_ra [0:63];
  int log_rb [0:63];
  int log_tw [0:63];
  int log_wa [0:63];
  int log_wb [0:63];

  fft_stage_scheduler #(
    .N_LOG2 (4),
    .RD_LAT (1),
    .BFU_LAT(5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .tw_addr  (tw_addr),
    .wr_en    (wr_en),
    .wr_addr_a(wr_addr_a),
    .wr_addr_b(wr_addr_b),
    .stage    (stage)
  );

  // clock
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d req=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_rd(int c);
    return (c >= 1) && (c <= LAST_C) && (((c - 1) % PER) < HALF);
  endfunction
  function automatic int m_stage(int c);
    return (c - 1) / PER;
  endfunction
  function automatic int m_a(int c);
    int s, k, span;
    s = m_stage(c); k = (c - 1) % PER; span = 1 << s;
    return (k / span) * 2 * span + (k % span);
  endfunction
  function automatic int m_b(int c);
    return m_a(c) + (1 << m_stage(c));
  endfunction
  function automatic int m_tw(int c);
    int s, k;
    s = m_stage(c); k = (c - 1) % PER;
    return (k % (1 << s)) << (N_LOG2 - 1 - s);
  endfunction

  // model: cycle count within a run, 0 when idle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mcyc = 0;
    else if (mcyc == 0) mcyc = start ? 1 : 0;
    else if (mcyc < DONE_C) mcyc = mcyc + 1;
    else mcyc = 0;
  end

  // compare process
  always @(negedge clk) begin
    bit e_rd, e_wr, e_busy;
    e_busy = (mcyc >= 1) && (mcyc <= LAST_C);
    e_rd   = m_rd(mcyc);
    e_wr   = (mcyc > PIPE) && m_rd(mcyc - PIPE);
    chk("busy", int'(busy), int'(e_busy));
    chk("done", int'(done), int'(mcyc == DONE_C));
    chk("rd_en", int'(rd_en), int'(e_rd));
    chk("wr_en", int'(wr_en), int'(e_wr));
    if (!rst_n) begin
      chk("rst_rd_addr_a", int'(rd_addr_a), 0);
      chk("rst_wr_addr_b", int'(wr_addr_b), 0);
    end else begin
      if (e_busy) chk("stage", int'(stage), m_stage(mcyc));
      if (e_rd) begin
        chk("rd_addr_a", int'(rd_addr_a), m_a(mcyc));
        chk("rd_addr_b", int'(rd_addr_b), m_b(mcyc));
        chk("tw_addr", int'(tw_addr), m_tw(mcyc));
      end
      if (e_wr) begin
        chk("wr_addr_a", int'(wr_addr_a), m_a(mcyc - PIPE));
        chk("wr_addr_b", int'(wr_addr_b), m_b(mcyc - PIPE));
      end
    end
    if (mcyc > 0 && mcyc < 64) begin
      log_ra[mcyc] = int'(rd_addr_a);
      log_rb[mcyc] = int'(rd_addr_b);
      log_tw[mcyc] = int'(tw_addr);
      log_wa[mcyc] = int'(wr_addr_a);
      log_wb[mcyc] = int'(wr_addr_b);
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // returns in the done cycle; cycle numbers relative to the start edge
  task automatic measure(output int done_at, output int busy_n,
                         output int rd_n, output int wr_n);
    done_at = 0; busy_n = 0; rd_n = 0; wr_n = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      busy_n += int'(busy);
      rd_n   += int'(rd_en);
      wr_n   += int'(wr_en);
      if (done) begin
        done_at = n;
        break;
      end
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
    chk({nm, "_rd_en"}, int'(rd_en), 0);
    chk({nm, "_wr_en"}, int'(wr_en), 0);
    chk({nm, "_rd_a"}, int'(rd_addr_a), 0);
    chk({nm, "_rd_b"}, int'(rd_addr_b), 0);
    chk({nm, "_tw"}, int'(tw_addr), 0);
    chk({nm, "_wr_a"}, int'(wr_addr_a), 0);
    chk({nm, "_wr_b"}, int'(wr_addr_b), 0);
    chk({nm, "_stage"}, int'(stage), 0);
  endtask

  // stimulus
  initial begin
    int d, b, r, w, nd, nr;
    rst_n = 1'b1;
    start = 1'b0;
    #3 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // single run with hand-computed expectations
    pulse_start();
    measure(d, b, r, w);
    chk("run1_done_cycle", d, 57);
    chk("run1_busy_cycles", b, 56);
    chk("run1_rd_count", r, 32);
    chk("run1_wr_count", w, 32);
    chk("s0k3_rd_a", log_ra[4], 6);
    chk("s0k3_rd_b", log_rb[4], 7);
    chk("s0k3_tw", log_tw[4], 0);
    chk("s1k3_rd_a", log_ra[18], 5);
    chk("s1k3_rd_b", log_rb[18], 7);
    chk("s1k3_tw", log_tw[18], 4);
    chk("s2k5_rd_a", log_ra[34], 9);
    chk("s2k5_rd_b", log_rb[34], 13);
    chk("s2k5_tw", log_tw[34], 2);
    chk("s3k5_rd_a", log_ra[48], 5);
    chk("s3k5_rd_b", log_rb[48], 13);
    chk("s3k5_tw", log_tw[48], 5);
    chk("s3k5_wr_a", log_wa[54], 5);
    chk("s3k5_wr_b", log_wb[54], 13);

    // start raised in the cycle after done and held: one run per IDLE visit
    @(posedge clk); #1 start = 1'b1;
    nd = 0; nr = 0;
    for (int i = 0; i < 117; i++) begin
      @(negedge clk);
      nd += int'(done);
      nr += int'(rd_en);
    end
    chk("held_start_dones", nd, 2);
    chk("held_start_reads", nr, 64);
    @(posedge clk); #1 start = 1'b0;
    measure(d, b, r, w);
    chk("held_start_tail_done_seen", int'(d > 0), 1);

    // reset in cycle 20 of a run
    @(posedge clk);
    pulse_start();
    repeat (19) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    w = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      w += int'(wr_en);
    end
    chk("post_rst_wr_count", w, 0);
    pulse_start();
    measure(d, b, r, w);
    chk("run2_done_cycle", d, 57);
    chk("run2_busy_cycles", b, 56);
    chk("run2_rd_count", r, 32);
    chk("run2_wr_count", w, 32);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
